// File: rtl/nios_128k_extended_led_sequencer.sv
// Avalon-MM LED pattern sequencer: direct, blink, rotate and bounce modes on a
// 10-bit LED bank, stepped by a programmable prescaler.
module nios_128k_extended_led_sequencer #(
  parameter logic [23:0] DEFAULT_PERIOD = 24'd4999999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  out_port
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  state_t      state_q, state_d;
  logic [9:0]  pattern_q, pattern_d;
  logic [1:0]  mode_q, mode_d;
  logic        run_q, run_d;
  logic [23:0] period_q, period_d;
  logic [23:0] cnt_q, cnt_d;
  logic [9:0]  sh_q, sh_d;
  logic        ph_q, ph_d;
  logic        dir_q, dir_d;
  logic [9:0]  disp_q, disp_d;
  logic [15:0] step_count_q, step_count_d;

  logic wr;
  logic run_start;
  logic step;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:24];
  assign wr = chipselect & ~write_n;

  always_comb begin
    pattern_d    = pattern_q;
    mode_d       = mode_q;
    run_d        = run_q;
    period_d     = period_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    ph_d         = ph_q;
    dir_d        = dir_q;
    disp_d       = disp_q;
    step_count_d = step_count_q;
    run_start    = 1'b0;
    step         = 1'b0;

    if (wr) begin
      case (address)
        2'd0: begin
          pattern_d = writedata[9:0];
          run_start = 1'b1;
        end
        2'd1: begin
          mode_d    = writedata[1:0];
          run_d     = writedata[2];
          run_start = writedata[2];
        end
        2'd2:    period_d = writedata[23:0];
        default: step_count_d = 16'd0;
      endcase
    end

    state_d = (run_d && (mode_d != 2'd0)) ? RUN : IDLE;

    // Any register write at a step edge swallows that step; only STATUS
    // writes leave the prescaler running.
    if (wr && (address != 2'd3)) begin
      cnt_d = 24'd0;
    end else if (state_q == RUN) begin
      if (cnt_q == period_q) begin
        cnt_d = 24'd0;
        step  = ~wr;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end else begin
      cnt_d = 24'd0;
    end

    if (run_start) begin
      sh_d   = pattern_d;
      ph_d   = 1'b1;
      dir_d  = 1'b0;
      disp_d = pattern_d;
    end else if (step) begin
      step_count_d = step_count_q + 16'd1;
      case (mode_q)
        MODE_BLINK: begin
          ph_d   = ~ph_q;
          disp_d = ph_q ? 10'd0 : pattern_q;
        end
        MODE_ROTATE: begin
          sh_d   = {sh_q[8:0], sh_q[9]};
          disp_d = sh_d;
        end
        MODE_BOUNCE: begin
          if (!dir_q && sh_q[9]) begin
            dir_d = 1'b1;
            sh_d  = sh_q >> 1;
          end else if (dir_q && sh_q[0]) begin
            dir_d = 1'b0;
            sh_d  = sh_q << 1;
          end else if (dir_q) begin
            sh_d  = sh_q >> 1;
          end else begin
            sh_d  = sh_q << 1;
          end
          disp_d = sh_d;
        end
        default: ;
      endcase
    end

    if (state_d == IDLE) begin
      disp_d = pattern_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pattern_q    <= 10'd0;
      mode_q       <= 2'd0;
      run_q        <= 1'b0;
      period_q     <= DEFAULT_PERIOD;
      cnt_q        <= 24'd0;
      sh_q         <= 10'd0;
      ph_q         <= 1'b0;
      dir_q        <= 1'b0;
      disp_q       <= 10'd0;
      step_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      run_q        <= run_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      ph_q         <= ph_d;
      dir_q        <= dir_d;
      disp_q       <= disp_d;
      step_count_q <= step_count_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {22'd0, pattern_q};
      2'd1:    readdata = {29'd0, run_q, mode_q};
      2'd2:    readdata = {8'd0, period_q};
      default: readdata = {step_count_q, 6'd0, disp_q};
    endcase
  end

  assign out_port = disp_q;

endmodule

// File: doc/nios_128k_extended_led_sequencer.md
# nios_128k_extended_led_sequencer

Avalon-MM slave LED pattern sequencer for the nios_128k_extended platform. It drives the 10-bit board LED bank either directly from a CPU-written pattern or autonomously, using blink, rotate and bounce sequences timed by a programmable prescaler. Once the CPU has configured a sequence, it needs no further bus traffic to animate the LEDs.

## Interface
- DEFAULT_PERIOD, 24'd4999999, PERIOD register reset value (steps every DEFAULT_PERIOD+1 clocks)
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select: 0 DATA, 1 CONTROL, 2 PERIOD, 3 STATUS
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write = chipselect & ~write_n
- writedata  in  32  write data
- readdata  out  32  combinational read data, zero wait states, read latency 0; unused bits read 0
- out_port  out  10  LED drive, registered (display register)

## Operation
- DATA (addr 0, R/W): pattern[9:0]; reset 0.
- CONTROL (addr 1, R/W): [1:0] mode (0 direct, 1 blink, 2 rotate, 3 bounce); [2] run; reset 0.
- PERIOD (addr 2, R/W): [23:0] step period minus one; reset DEFAULT_PERIOD.
- STATUS (addr 3, R): [9:0] live out_port; [31:16] step_count. Any write to addr 3 clears step_count to 0.
- Internal state:
  - prescaler cnt[23:0]
  - shift register sh[9:0]
  - blink phase ph (1 = on)
  - bounce direction dir (0 = left)
- Run-start event: any write to CONTROL with run=1, or any write to DATA. It sets cnt←0, sh←pattern (new value if DATA is written), ph←1, dir←0, disp←pattern.
- Writing PERIOD sets cnt←0.
- FSM, two states:
  - IDLE (run=0 or mode=0): disp = pattern continuously; cnt held at 0; no steps.
  - RUN (run=1 and mode≠0): cnt increments each cycle. At cnt==PERIOD: cnt←0, a step event occurs, and step_count increments (16-bit, wraps 0xFFFF→0).
- Step actions:
  - blink: ph←~ph; disp = ph ? pattern : 0.
  - rotate: sh←{sh[8:0],sh[9]}; disp=sh.
  - bounce (logical shift, zero fill):
    - if dir=0 and sh[9]=1: dir←1, sh←sh>>1
    - else if dir=1 and sh[0]=1: dir←0, sh←sh<<1
    - else shift in dir
    - disp=sh
- Clearing run or writing mode=0 returns to IDLE: disp←pattern at that edge; sh, ph, dir hold until the next run-start.
- Mode change while run=1 counts as a run-start (CONTROL write with run=1).
- Pattern 0 in rotate/bounce stays 0 (legal, no lockup).
- Simultaneous step event and register write at the same edge: the write wins; its reload/reset rules apply and the step is discarded (no count increment).
- Reset (asynchronous, any time, including mid-sequence): all registers to reset values, out_port=0, step_count=0, IDLE.

## Timing
- Write sampled at rising edge N; register and out_port show the new value immediately after edge N; readdata reflects it from cycle N+1.
- PERIOD=P yields one step every P+1 clocks. P=0 gives one step per clock.
- First step after run-start lands at edge run_start+P+1.
- out_port changes only at step edges, write edges or reset; it is glitch-free (driven directly from a flop).

## Test plan
- Reset, then read all 4 addresses: out_port=0, DATA=0, CONTROL=0, PERIOD=DEFAULT_PERIOD, STATUS=0.
- Direct: write DATA=0x2A5 → out_port=0x2A5 after that edge; read addr 0 = 0x000002A5.
- Blink: PERIOD=3, DATA=0x3FF, CONTROL=0x5 → out_port 0x3FF for 4 clocks, 0 for 4, repeating; after 8 clocks STATUS[31:16]=2.
- Rotate: PERIOD=0, DATA=0x201, CONTROL=0x6 → successive clocks 0x201, 0x003, 0x006, 0x00C; 10 steps return 0x201.
- Bounce: PERIOD=0, DATA=0x100, CONTROL=0x7 → 0x100, 0x200, 0x100, 0x080, … 0x001, 0x002; then write CONTROL=0x3 → out_port=0x100 next edge; write addr 3 → step_count=0.
- Collision/reset: step edge coincident with a PERIOD write → no step and step_count unchanged. Assert reset_n mid-rotate between edges → out_port=0 immediately, without waiting for a clock.
